// File: rtl/sram_stream_loader.sv
// Ready/valid INT8 stream to single-bank SRAM fill engine with programmed base and length.
// Optional error flag logic is enabled by defining LOADER_ERR_CHECK_EN.

module sram_stream_loader #(
    parameter int NUM_SRAMS      = 4,
    parameter int MAX_ADDR_WIDTH = 16,
    parameter int INT8_WIDTH     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [$clog2(NUM_SRAMS)-1:0]         bank_sel,
    input  logic [MAX_ADDR_WIDTH-1:0]            base_addr,
    input  logic [MAX_ADDR_WIDTH:0]              length,
    input  logic                                 s_valid,
    input  logic [INT8_WIDTH-1:0]                s_data,
    output logic                                 s_ready,
    output logic [NUM_SRAMS-1:0]                 sram_en,
    output logic [NUM_SRAMS-1:0]                 sram_we,
    output logic [NUM_SRAMS*MAX_ADDR_WIDTH-1:0]  sram_addr,
    output logic [NUM_SRAMS*INT8_WIDTH-1:0]      sram_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    // state | meaning
    // IDLE  | waiting for start; zero-length starts only pulse done
    // LOAD  | accepting bytes, one write strobe per handshake
    // FLUSH | final strobe and done on the bus, returning to IDLE

    localparam int BW = $clog2(NUM_SRAMS);
    localparam int AW = MAX_ADDR_WIDTH;
    localparam int CW = MAX_ADDR_WIDTH + 1;
    localparam int DW = INT8_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bank_q, bank_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   remain_q, remain_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            s_ready_q, s_ready_d;
    logic            err_q, err_d;
    logic            bank_ok;

    generate
        if ((1 << BW) == NUM_SRAMS) begin : g_bank_full
            assign bank_ok = 1'b1;
        end else begin : g_bank_chk
            assign bank_ok = (bank_sel < BW'(NUM_SRAMS));
        end
    endgenerate

`ifdef LOADER_ERR_CHECK_EN
    localparam logic [AW+1:0] ADDR_SPAN = {2'b01, {AW{1'b0}}};
    logic wrap;
    assign wrap = (({2'b00, base_addr} + {1'b0, length}) > ADDR_SPAN);
`endif

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        ptr_d     = ptr_q;
        remain_d  = remain_q;
        wr_d      = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        done_d    = 1'b0;
        busy_d    = busy_q;
        s_ready_d = s_ready_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (start && bank_ok) begin
                    if (length != '0) begin
                        bank_d    = bank_sel;
                        ptr_d     = base_addr;
                        remain_d  = length;
                        state_d   = S_LOAD;
                        busy_d    = 1'b1;
                        s_ready_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (s_valid && s_ready_q) begin
                    wr_d      = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = s_data;
                    ptr_d     = ptr_q + AW'(1);
                    remain_d  = remain_q - CW'(1);
                    // terminal count: this handshake carries the last byte
                    if (remain_q == CW'(1)) begin
                        state_d   = S_FLUSH;
                        s_ready_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                s_ready_d = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                s_ready_d = 1'b0;
            end
        endcase

`ifdef LOADER_ERR_CHECK_EN
        // a wrapping job still runs; the flag only records it
        if (start && (busy_q || !bank_ok || wrap)) begin
            err_d = 1'b1;
        end
`else
        err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bank_q    <= '0;
            ptr_q     <= '0;
            remain_q  <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            s_ready_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            ptr_q     <= ptr_d;
            remain_q  <= remain_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            s_ready_q <= s_ready_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        sram_en   = '0;
        sram_we   = '0;
        sram_addr = '0;
        sram_data = '0;
        if (wr_q) begin
            sram_en[bank_q]                       = 1'b1;
            sram_we[bank_q]                       = 1'b1;
            sram_addr[int'(bank_q)*AW +: AW]      = wr_addr_q;
            sram_data[int'(bank_q)*DW +: DW]      = wr_data_q;
        end
    end

    assign s_ready = s_ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_sram_stream_loader.sv
// Scoreboarded bench for sram_stream_loader: expected bus/done per cycle queued at drive time.
// Build with LOADER_ERR_CHECK_EN defined to exercise the error flag expectations.

module tb_sram_stream_loader;

    localparam int NS = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        bank_sel;
    logic [AW-1:0]     base_addr;
    logic [AW:0]       length;
    logic              s_valid;
    logic [DW-1:0]     s_data;
    logic              s_ready;
    logic [NS-1:0]     sram_en;
    logic [NS-1:0]     sram_we;
    logic [NS*AW-1:0]  sram_addr;
    logic [NS*DW-1:0]  sram_data;
    logic              busy;
    logic              done;
    logic              err;

    sram_stream_loader #(.NUM_SRAMS(NS), .MAX_ADDR_WIDTH(AW), .INT8_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel),
        .base_addr(base_addr), .length(length), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_data(sram_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        bit            wr;
        int            bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            dn;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
`ifdef LOADER_ERR_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle bus monitor: a queued entry due this cycle defines the bus, otherwise all zero.
    always @(negedge clk) begin : mon
        exp_t          e;
        logic [NS-1:0] een;
        logic [NS*AW-1:0] eaddr;
        logic [NS*DW-1:0] edata;
        logic          edone;
        een = '0; eaddr = '0; edata = '0; edone = 1'b0;
        if (q.size() > 0 && q[0].due < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL stale_entry cyc=%0d due=%0d never observed", cyc, q[0].due);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.wr) begin
                een[e.bank]             = 1'b1;
                eaddr[e.bank*AW +: AW]  = e.addr;
                edata[e.bank*DW +: DW]  = e.data;
            end
            edone = e.dn;
        end
        vectors++;
        if (sram_en !== een || sram_we !== een || sram_addr !== eaddr ||
            sram_data !== edata || done !== edone) begin
            miscompares++;
            $display("FAIL bus cyc=%0d got en=%h we=%h addr=%h data=%h done=%b want en=%h addr=%h data=%h done=%b",
                     cyc, sram_en, sram_we, sram_addr, sram_data, done, een, eaddr, edata, edone);
        end
    end

    // Drives one job; pushes every expected write at the moment its byte is presented.
    task automatic load_job(input int bank, input logic [AW-1:0] base, input int len,
                            input logic [DW-1:0] d0, input logic [15:0] pat, input int patlen,
                            input int bs_idx);
        int   sent = 0;
        int   ci = 0;
        logic v;
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; bank_sel = 2'(bank); base_addr = base; length = (AW+1)'(len);
        @(posedge clk); #1;
        start = 1'b0;
        while (sent < len && ci < 200) begin
            v = (ci < patlen) ? pat[ci] : 1'b1;
            s_valid = v;
            s_data  = d0 + 8'(sent * 17);
            start   = (v && sent == bs_idx);
            if (start) begin
                bank_sel  = 2'(bank + 1);
                base_addr = base ^ 16'h0F00;
                length    = 17'd2;
            end
            if (v) begin
                e.due = cyc + 1; e.wr = 1'b1; e.bank = bank;
                e.addr = base + AW'(sent); e.data = s_data; e.dn = (sent == len - 1);
                q.push_back(e);
                sent++;
            end
            ci++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0; start = 1'b0; s_data = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (sram_en !== '0 || sram_we !== '0 || sram_addr !== '0 || sram_data !== '0) begin
            miscompares++;
            $display("FAIL reset_bus got en=%h we=%h addr=%h data=%h want 0", sram_en, sram_we, sram_addr, sram_data);
        end
        vectors++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got s_ready=%b busy=%b done=%b err=%b want 0", s_ready, busy, done, err);
        end
        @(posedge clk); #3;
        rst = 1'b1;
    endtask

    task automatic test_basic_fill();
        load_job(2, 16'h0010, 4, 8'h11, 16'h000F, 4, -1);
        vectors++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_flush got busy=%b s_ready=%b want busy=1 s_ready=0", busy, s_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_idle got busy=%b pending=%0d want busy=0 pending=0", busy, q.size());
        end
    endtask

    task automatic test_stalled_stream();
        load_job(1, 16'h0120, 3, 8'h50, 16'b11001, 5, -1);
        vectors++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_flush got busy=%b s_ready=%b want busy=1 s_ready=0", busy, s_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_idle got busy=%b pending=%0d want busy=0 pending=0", busy, q.size());
        end
    endtask

    task automatic test_zero_length();
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; bank_sel = 2'd1; base_addr = 16'h0033; length = '0;
        e.due = cyc + 1; e.wr = 1'b0; e.bank = 0; e.addr = '0; e.data = '0; e.dn = 1'b1;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_busy got busy=%b s_ready=%b want 0 0", busy, s_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || q.size() != 0) begin
            miscompares++;
            $display("FAIL zero_len_after got busy=%b pending=%0d want busy=0 pending=0", busy, q.size());
        end
    endtask

    task automatic test_wrap();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_pre_err got %b want 0", err);
        end
        load_job(0, 16'hFFFE, 4, 8'hC0, 16'h000F, 4, -1);
        vectors++;
        if (err !== ERR_ON) begin
            miscompares++;
            $display("FAIL wrap_err got %b want %b", err, ERR_ON);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_idle got busy=%b pending=%0d want busy=0 pending=0", busy, q.size());
        end
    endtask

    task automatic test_reset_mid_job();
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; bank_sel = 2'd3; base_addr = 16'h0200; length = 17'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = 8'h70 + 8'(i);
            e.due = cyc + 1; e.wr = 1'b1; e.bank = 3; e.addr = 16'h0200 + AW'(i);
            e.data = s_data; e.dn = 1'b0;
            q.push_back(e);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        @(negedge clk); #2;
        rst = 1'b0;
        q.delete();
        #1;
        vectors++;
        if (sram_en !== '0 || sram_we !== '0 || sram_addr !== '0 || sram_data !== '0) begin
            miscompares++;
            $display("FAIL abort_bus got en=%h we=%h addr=%h data=%h want 0", sram_en, sram_we, sram_addr, sram_data);
        end
        vectors++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_ctrl got busy=%b s_ready=%b done=%b err=%b want 0", busy, s_ready, done, err);
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        load_job(0, 16'h0040, 1, 8'hA5, 16'h0001, 1, -1);
        vectors++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rejob_flush got busy=%b s_ready=%b want busy=1 s_ready=0", busy, s_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || q.size() != 0) begin
            miscompares++;
            $display("FAIL rejob_idle got busy=%b pending=%0d want busy=0 pending=0", busy, q.size());
        end
    endtask

    task automatic test_start_while_busy();
        load_job(1, 16'h0100, 3, 8'h0A, 16'h0007, 3, 1);
        vectors++;
        if (err !== ERR_ON) begin
            miscompares++;
            $display("FAIL busy_start_err got %b want %b", err, ERR_ON);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || q.size() != 0) begin
            miscompares++;
            $display("FAIL busy_start_idle got busy=%b s_ready=%b pending=%0d want 0 0 0", busy, s_ready, q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start_nojob got busy=%b want 0", busy);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; bank_sel = '0; base_addr = '0; length = '0;
        s_valid = 1'b0; s_data = '0;
        test_reset();
        test_basic_fill();
        test_stalled_stream();
        test_zero_length();
        test_wrap();
        test_reset_mid_job();
        test_start_while_busy();
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sram_stream_loader.md
Name: sram_stream_loader

Overview:
- Upstream fill stage for the multi-bank SRAM array.
- Accepts a ready/valid INT8 byte stream and writes it into one selected bank, starting at a programmed base address for a programmed length.
- Drives the packed per-bank en/we/addr/data_in buses directly.
- Lets a host/DMA preload weights or activations before compute starts.

Parameters:
- NUM_SRAMS, 4, number of SRAM banks driven.
- MAX_ADDR_WIDTH, 16, per-bank address field width in the packed addr bus.
- INT8_WIDTH, 8, per-bank data field width in the packed data_in bus.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job request
- bank_sel  in  $clog2(NUM_SRAMS)  target bank, sampled on accepted start
- base_addr  in  MAX_ADDR_WIDTH  first write address, sampled on accepted start
- length  in  MAX_ADDR_WIDTH+1  byte count, sampled on accepted start
- s_valid  in  1  stream byte valid
- s_data  in  INT8_WIDTH  stream byte
- s_ready  out  1  loader can accept a byte
- sram_en  out  NUM_SRAMS  per-bank enable
- sram_we  out  NUM_SRAMS  per-bank write enable
- sram_addr  out  NUM_SRAMS*MAX_ADDR_WIDTH  packed addresses; bank i at [i*MAX_ADDR_WIDTH +: MAX_ADDR_WIDTH]
- sram_data  out  NUM_SRAMS*INT8_WIDTH  packed write data; bank i at [i*INT8_WIDTH +: INT8_WIDTH]
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters and latched job fields cleared.
- FSM states: IDLE, LOAD, FLUSH.
- IDLE:
  - s_ready=0, busy=0.
  - start=1 and length!=0 and bank_sel<NUM_SRAMS: latch bank, base and length; count=0; go to LOAD.
  - start=1 and length==0: no writes; done=1 next cycle; stay IDLE.
- LOAD:
  - busy=1, s_ready=1.
  - Each handshake (s_valid & s_ready) registers one write. Next cycle: sram_en[bank]=sram_we[bank]=1, addr field = (base+count) mod 2^MAX_ADDR_WIDTH (wraps silently), data field = s_data.
  - count increments per handshake. No bubbles: back-to-back handshakes give back-to-back writes.
  - Handshake with count==length-1: go to FLUSH; s_ready drops to 0 the following cycle.
- FLUSH:
  - The final write strobe is on the bus this cycle, and done=1 in the same cycle.
  - busy=1, s_ready=0.
  - Go to IDLE next cycle.
- Outputs when no write is strobed:
  - All sram_en/sram_we are 0, and addr/data fields are 0 for every bank.
  - Non-selected banks are always 0.
- Latency: byte handshake to SRAM write strobe is exactly 1 cycle.
- s_valid=0 in LOAD: no write; addr/data fields return to 0; count holds.
- start while busy: ignored; the job in progress is unaffected.
- Reset mid-job: immediate abort, outputs 0, no done pulse, partial writes are not rolled back.
- Length up to 2^MAX_ADDR_WIDTH is supported; count width is MAX_ADDR_WIDTH+1.

Optional Feature:
- Macro: LOADER_ERR_CHECK_EN.
- Defined: err sets (sticky until reset) on any of:
  - start while busy;
  - start with bank_sel>=NUM_SRAMS;
  - address wrap, i.e. base+length > 2^MAX_ADDR_WIDTH, detected at start.
- Defined, wrap case: the job still runs and wraps.
- Defined, invalid bank_sel: start is rejected, no job runs, no done pulse.
- Not defined: err is tied 0, and invalid-bank starts are silently ignored.

Test Plan:
- Basic fill:
  - Stimulus: bank_sel=2, base=0x0010, length=4, bytes 0x11,0x22,0x33,0x44 with s_valid held high.
  - Response: bank 2 written at addr 0x10..0x13 on 4 consecutive cycles, each 1 cycle after its handshake. done pulses with the 4th write strobe. Other banks' en/we stay 0.
- Stalled stream:
  - Stimulus: length=3, s_valid pattern 1,0,0,1,1.
  - Response: writes only on the cycles after handshakes, addresses base, base+1, base+2 with no gaps. done is coincident with the last strobe.
- Zero length:
  - Stimulus: start with length=0.
  - Response: no sram_en activity; done=1 on the next cycle; busy stays 0.
- Wrap:
  - Stimulus: base=0xFFFE, length=4.
  - Response: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001. With LOADER_ERR_CHECK_EN, err=1 from the cycle after start.
- Reset mid-job:
  - Stimulus: rst asserted after 2 of 5 bytes.
  - Response: all outputs 0 asynchronously, no done pulse. A new job of length=1 afterwards completes normally.
- start while busy:
  - Stimulus: second start during LOAD.
  - Response: ignored; the original job completes intact. err=1 only when LOADER_ERR_CHECK_EN is defined.
